// File: rtl/turnstile_pkg.sv
// turnstile_pkg: state encodings and default timing constants shared by the
// turnstile gate controller and by the upstream access-code FSM's status decode.
`timescale 1ns/100ps

package turnstile_pkg;

  // Raw encodings. Decode logic elsewhere compares gate_state against these.
  localparam logic [1:0] ENC_LOCKED   = 2'b00;
  localparam logic [1:0] ENC_UNLOCKED = 2'b01;
  localparam logic [1:0] ENC_ROTATING = 2'b10;
  localparam logic [1:0] ENC_ALARM    = 2'b11;

  typedef enum logic [1:0] {
    ST_LOCKED   = ENC_LOCKED,
    ST_UNLOCKED = ENC_UNLOCKED,
    ST_ROTATING = ENC_ROTATING,
    ST_ALARM    = ENC_ALARM
  } gate_state_e;

  // Default timing constants, in clock cycles.
  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam int DEF_ROTATE_CYCLES  = 4;
  localparam int DEF_ALARM_HOLD     = 8;
  localparam int DEF_CNT_W          = 8;

  // Largest of three values, used to size the shared timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/turnstile_gate_timer.sv
// gate_timer: loadable down-counter shared by every timed state of the gate FSM.
// A load takes priority over a decrement; the count holds at zero instead of
// wrapping, so callers may keep dec asserted while they wait on another input.
`timescale 1ns/100ps

module gate_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Count register: load, or decrement while non-zero, else hold.
  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/turnstile_gate_ctrl.sv
// turnstile_gate_ctrl: drives the turnstile arm lock from the access-code grant.
// One grant releases the arm for one passage. The arm relocks when an unused grant
// expires or after a completed rotation. Pushing a locked arm raises the alarm.
// Completed passages are counted with saturation.
`timescale 1ns/100ps

module turnstile_gate_ctrl
  import turnstile_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int ROTATE_CYCLES  = DEF_ROTATE_CYCLES,
  parameter int ALARM_HOLD     = DEF_ALARM_HOLD,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             open_access_door,
  input  logic             pass_sensor,
  output logic             gate_unlock,
  output logic             alarm,
  output logic             timeout_pulse,
  output logic [CNT_W-1:0] pass_count,
  output logic [1:0]       gate_state
);

  localparam int TIMER_W = $clog2(max3(TIMEOUT_CYCLES, ROTATE_CYCLES, ALARM_HOLD));

  // Timer reload values. Each is truncated to the shared timer width.
  localparam logic [TIMER_W-1:0] TMR_TIMEOUT = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TMR_ROTATE  = TIMER_W'(ROTATE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TMR_ALARM   = TIMER_W'(ALARM_HOLD - 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  gate_state_e        r_state;
  gate_state_e        w_next_state;
  logic               w_tmr_load;
  logic               w_tmr_dec;
  logic [TIMER_W-1:0] w_tmr_load_val;
  logic               w_tmr_zero;
  logic               w_timeout;
  logic               w_pass_done;

  logic               r_gate_unlock;
  logic               r_alarm;
  logic               r_timeout_pulse;
  logic [CNT_W-1:0]   r_pass_count;

  gate_timer #(
    .W (TIMER_W)
  ) u_gate_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_dec      (w_tmr_dec),
    .i_load_val (w_tmr_load_val),
    .o_zero     (w_tmr_zero)
  );

  // Next-state and timer control for the gate FSM.
  // NOTE: every signal assigned here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_tmr_load     = 1'b0;
    w_tmr_dec      = 1'b0;
    w_tmr_load_val = '0;
    w_timeout      = 1'b0;
    w_pass_done    = 1'b0;

    unique case (r_state)
      ST_LOCKED: begin
        // The grant wins when it coincides with a push on the arm.
        if (open_access_door) begin
          w_next_state   = ST_UNLOCKED;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = TMR_TIMEOUT;
        end else if (pass_sensor) begin
          w_next_state   = ST_ALARM;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = TMR_ALARM;
        end
      end

      ST_UNLOCKED: begin
        if (pass_sensor) begin
          w_next_state   = ST_ROTATING;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = TMR_ROTATE;
        end else if (open_access_door) begin
          // A repeated grant only restarts the wait; it never banks a second passage.
          w_tmr_load     = 1'b1;
          w_tmr_load_val = TMR_TIMEOUT;
        end else if (w_tmr_zero) begin
          w_next_state = ST_LOCKED;
          w_timeout    = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      ST_ROTATING: begin
        // Grants are ignored here; the arm stays free until the minimum rotation
        // time has elapsed and the sensor reports the arm at rest.
        if (w_tmr_zero && !pass_sensor) begin
          w_next_state = ST_LOCKED;
          w_pass_done  = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      ST_ALARM: begin
        if (w_tmr_zero && !pass_sensor) begin
          w_next_state = ST_LOCKED;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      default: begin
        w_next_state = ST_LOCKED;
      end
    endcase
  end

  // State register.
  // NOTE: the asynchronous reset forces a known state and outputs immediately,
  // without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_LOCKED;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gate_unlock   <= 1'b0;
      r_alarm         <= 1'b0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_gate_unlock   <= (w_next_state == ST_UNLOCKED) || (w_next_state == ST_ROTATING);
      r_alarm         <= (w_next_state == ST_ALARM);
      r_timeout_pulse <= w_timeout;
    end
  end

  // Saturating passage counter; a rotation interrupted by reset is never counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pass_count <= '0;
    end else if (w_pass_done && (r_pass_count != CNT_MAX)) begin
      r_pass_count <= r_pass_count + CNT_W'(1);
    end
  end

  assign gate_unlock   = r_gate_unlock;
  assign alarm         = r_alarm;
  assign timeout_pulse = r_timeout_pulse;
  assign pass_count    = r_pass_count;
  assign gate_state    = r_state;

endmodule

// File: tb/tb_turnstile_gate_ctrl.sv
// Directed testbench for turnstile_gate_ctrl. A default-width instance and a
// 2-bit-counter instance share the same stimulus; expected values are hand-computed.
`timescale 1ns/100ps

module tb_turnstile_gate_ctrl;

  logic       clk;
  logic       reset;
  logic       open_access_door;
  logic       pass_sensor;

  logic       gate_unlock;
  logic       alarm;
  logic       timeout_pulse;
  logic [7:0] pass_count;
  logic [1:0] gate_state;

  logic       s_gate_unlock;
  logic       s_alarm;
  logic       s_timeout_pulse;
  logic [1:0] s_pass_count;
  logic [1:0] s_gate_state;

  int n_compared   = 0;
  int n_mismatched = 0;

  turnstile_gate_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .open_access_door (open_access_door),
    .pass_sensor      (pass_sensor),
    .gate_unlock      (gate_unlock),
    .alarm            (alarm),
    .timeout_pulse    (timeout_pulse),
    .pass_count       (pass_count),
    .gate_state       (gate_state)
  );

  turnstile_gate_ctrl #(
    .CNT_W (2)
  ) dut_sat (
    .clk              (clk),
    .reset            (reset),
    .open_access_door (open_access_door),
    .pass_sensor      (pass_sensor),
    .gate_unlock      (s_gate_unlock),
    .alarm            (s_alarm),
    .timeout_pulse    (s_timeout_pulse),
    .pass_count       (s_pass_count),
    .gate_state       (s_gate_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One grant followed by a one-cycle push; the arm must stay free for the
  // full rotation time and relock on the fifth edge after the grant.
  task automatic do_passage(input string tag);
    open_access_door = 1'b1;
    tick();
    check({tag, "_unlocked"}, 32'(gate_state), 32'h1);
    open_access_door = 1'b0;
    pass_sensor      = 1'b1;
    tick();
    check({tag, "_rotating"}, 32'(gate_state), 32'h2);
    pass_sensor = 1'b0;
    tick();
    tick();
    tick();
    check({tag, "_min_rotate"}, 32'(gate_state), 32'h2);
    tick();
    check({tag, "_relocked"}, 32'(gate_state), 32'h0);
    check({tag, "_relocked_sat"}, 32'(s_gate_state), 32'h0);
  endtask

  initial begin
    int n;
    int first;
    int exp_sat[5];

    reset            = 1'b0;
    open_access_door = 1'b0;
    pass_sensor      = 1'b0;

    // 1. Asynchronous reset in mid-cycle, before the first clock edge.
    #2.5 reset = 1'b1;
    #0.5;
    check("rst_unlock",  32'(gate_unlock),   32'h0);
    check("rst_alarm",   32'(alarm),         32'h0);
    check("rst_tpulse",  32'(timeout_pulse), 32'h0);
    check("rst_count",   32'(pass_count),    32'h0);
    check("rst_state",   32'(gate_state),    32'h0);
    check("rst_count_s", 32'(s_pass_count),  32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("idle_state", 32'(gate_state), 32'h0);

    // 2. Grant then a 6-cycle push.
    open_access_door = 1'b1;
    tick();
    check("t2_unlock", 32'(gate_unlock), 32'h1);
    check("t2_state01", 32'(gate_state), 32'h1);
    open_access_door = 1'b0;
    pass_sensor      = 1'b1;
    tick();
    check("t2_state10", 32'(gate_state), 32'h2);
    check("t2_unlock_rot", 32'(gate_unlock), 32'h1);
    for (int i = 0; i < 5; i++) tick();
    check("t2_still_rot", 32'(gate_state), 32'h2);
    pass_sensor = 1'b0;
    tick();
    check("t2_state00", 32'(gate_state), 32'h0);
    check("t2_count", 32'(pass_count), 32'h1);
    check("t2_relock", 32'(gate_unlock), 32'h0);

    // 3. Unused grant expires 16 cycles after unlock.
    open_access_door = 1'b1;
    tick();
    check("t3_unlock", 32'(gate_unlock), 32'h1);
    open_access_door = 1'b0;
    n     = 0;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (timeout_pulse === 1'b1) begin
        n++;
        if (first < 0) first = i;
      end
    end
    check("t3_pulse_pos", 32'(first), 32'd16);
    check("t3_pulse_len", 32'(n), 32'd1);
    check("t3_relock", 32'(gate_unlock), 32'h0);
    check("t3_count", 32'(pass_count), 32'h1);

    // 4a. Forced entry for 3 cycles: alarm held for ALARM_HOLD cycles.
    pass_sensor = 1'b1;
    tick();
    check("t4_alarm", 32'(alarm), 32'h1);
    check("t4_state11", 32'(gate_state), 32'h3);
    check("t4_locked", 32'(gate_unlock), 32'h0);
    n = 1;
    tick();
    if (alarm === 1'b1) n++;
    tick();
    if (alarm === 1'b1) n++;
    pass_sensor = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (alarm !== 1'b1) break;
      n++;
    end
    check("t4_alarm_len", 32'(n), 32'd8);
    check("t4_back_locked", 32'(gate_state), 32'h0);

    // 4b. Push held for 12 cycles keeps the alarm until the cycle after release.
    pass_sensor = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (alarm === 1'b1) n++;
    end
    pass_sensor = 1'b0;
    tick();
    check("t4_hold_len", 32'(n), 32'd12);
    check("t4_hold_clear", 32'(alarm), 32'h0);
    check("t4_count", 32'(pass_count), 32'h1);

    // 5a. Grant and push in the same locked cycle: the grant wins.
    open_access_door = 1'b1;
    pass_sensor      = 1'b1;
    tick();
    check("t5_state01", 32'(gate_state), 32'h1);
    check("t5_no_alarm", 32'(alarm), 32'h0);
    open_access_door = 1'b0;
    pass_sensor      = 1'b0;

    // 5b. Re-grant when the timer reads 2 pushes the timeout 16 cycles later.
    for (int i = 0; i < 13; i++) tick();
    open_access_door = 1'b1;
    tick();
    open_access_door = 1'b0;
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (timeout_pulse === 1'b1) begin
        first = i;
        break;
      end
    end
    check("t5_regrant_pos", 32'(first), 32'd16);
    tick();
    check("t5_pulse_end", 32'(timeout_pulse), 32'h0);

    // 6. Saturation of a 2-bit counter over five passages.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_rst_count", 32'(pass_count), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    exp_sat[0] = 1;
    exp_sat[1] = 2;
    exp_sat[2] = 3;
    exp_sat[3] = 3;
    exp_sat[4] = 3;
    for (int i = 0; i < 5; i++) begin
      do_passage($sformatf("pass%0d", i + 1));
      check($sformatf("sat_count%0d", i + 1), 32'(s_pass_count), 32'(exp_sat[i]));
      check($sformatf("full_count%0d", i + 1), 32'(pass_count), 32'(i + 1));
    end

    // Reset during a rotation discards the passage.
    open_access_door = 1'b1;
    tick();
    open_access_door = 1'b0;
    pass_sensor      = 1'b1;
    tick();
    check("t6_mid_rot", 32'(gate_state), 32'h2);
    #2 reset = 1'b1;
    #1;
    check("t6_rot_rst_count", 32'(pass_count), 32'h0);
    check("t6_rot_rst_count_s", 32'(s_pass_count), 32'h0);
    check("t6_rot_rst_state", 32'(gate_state), 32'h0);
    check("t6_rot_rst_unlock", 32'(gate_unlock), 32'h0);
    pass_sensor = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("t6_after_rst_count", 32'(pass_count), 32'h0);
    check("t6_after_rst_alarm", 32'(alarm), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
